// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder and instruction-memory program loader
//
// Takes decoded instruction fields over a valid/ready handshake, packs them into
// 32-bit machine words (lw, sw, R-type, beq, I-ALU, jal) and writes them to
// consecutive instruction-memory words starting at address 0.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   start                     begin a load session (IDLE, DONE, ERROR only)
//   in_valid / in_ready       field handshake; in_ready high only in ACCEPT
//   in_kind                   0 lw, 1 sw, 2 R, 3 beq, 4 I-ALU, 5 jal, 6/7 illegal
//   in_rd, in_rs1, in_rs2     register fields
//   in_funct3, in_funct7b5    R-type / I-ALU function select
//   in_imm                    21-bit signed byte immediate
//   in_last                   final instruction of the program
//   mem_we, mem_addr, mem_wdata  instruction-memory write port (registered)
//   count                     words written this session
//   busy, done, err, err_code session status

module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [20:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] K_LW   = 3'd0;
    localparam logic [2:0] K_SW   = 3'd1;
    localparam logic [2:0] K_R    = 3'd2;
    localparam logic [2:0] K_BEQ  = 3'd3;
    localparam logic [2:0] K_IALU = 3'd4;
    localparam logic [2:0] K_JAL  = 3'd5;

    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_KIND  = 2'b01;
    localparam logic [1:0] E_IMM   = 2'b10;
    localparam logic [1:0] E_OVFL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;

    logic [31:0]         enc_word;
    logic [1:0]          enc_code;
    logic                fits12;
    logic                fits13;
    logic [ADDR_W:0]     count_inc;

    // Sign-extension checks: the immediate fits N bits when every bit above
    // N-1 is a copy of bit N-1.
    assign fits12 = (&in_imm[20:11]) | ~(|in_imm[20:11]);
    assign fits13 = (&in_imm[20:12]) | ~(|in_imm[20:12]);

    always_comb begin
        enc_word = 32'h0;
        enc_code = E_NONE;
        case (in_kind)
            K_LW: begin
                enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
                if (!fits12) enc_code = E_IMM;
            end
            K_SW: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
                if (!fits12) enc_code = E_IMM;
            end
            K_R: begin
                enc_word = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_REG};
            end
            K_BEQ: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                            in_imm[4:1], in_imm[11], OP_BRANCH};
                if (!fits13 || in_imm[0]) enc_code = E_IMM;
            end
            K_IALU: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
                if (!fits12) enc_code = E_IMM;
            end
            K_JAL: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
                if (in_imm[0]) enc_code = E_IMM;
            end
            default: begin
                enc_code = E_KIND;
            end
        endcase
    end

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        count_d     = count_q;
        err_code_d  = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCEPT;
                    count_d = '0;
                end
            end
            S_ACCEPT: begin
                // in_ready_q is high in every ACCEPT cycle, so in_valid alone
                // completes the handshake here.
                if (in_valid) begin
                    if (enc_code != E_NONE) begin
                        state_d    = S_ERROR;
                        err_code_d = enc_code;
                    end else begin
                        state_d     = S_WRITE;
                        mem_wdata_d = enc_word;
                        mem_addr_d  = count_q[ADDR_W-1:0];
                        last_d      = in_last;
                    end
                end
            end
            S_WRITE: begin
                count_d = count_inc;
                if (last_q) begin
                    state_d = S_DONE;
                end else if (count_inc[ADDR_W]) begin
                    // Memory is full; the word just written stands, nothing wraps.
                    state_d    = S_ERROR;
                    err_code_d = E_OVFL;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_ACCEPT;
                    count_d    = '0;
                    err_code_d = E_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        mem_we_d   = (state_d == S_WRITE);
        in_ready_d = (state_d == S_ACCEPT);
        busy_d     = (state_d == S_ACCEPT) || (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= E_NONE;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder (ADDR_W=6 and ADDR_W=2 instances)

module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_kind = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7b5 = 1'b0;
    logic [20:0] in_imm = '0;
    logic        in_last = 1'b0;

    logic        rdy_a, we_a, busy_a, done_a, err_a;
    logic [5:0]  addr_a;
    logic [31:0] wdata_a;
    logic [6:0]  count_a;
    logic [1:0]  code_a;

    logic        rdy_b, we_b, busy_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  count_b;
    logic [1:0]  code_b;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(6)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .in_valid(in_valid),
        .in_ready(rdy_a), .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_imm(in_imm), .in_last(in_last), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .count(count_a), .busy(busy_a), .done(done_a),
        .err(err_a), .err_code(code_a)
    );

    instr_encoder #(.ADDR_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .in_valid(in_valid),
        .in_ready(rdy_b), .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_imm(in_imm), .in_last(in_last), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .count(count_b), .busy(busy_b), .done(done_b),
        .err(err_b), .err_code(code_b)
    );

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb_q[$];
    int  checks = 0;
    int  failures = 0;
    bit  sel = 1'b0;
    int  exp_addr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic sel_rdy();
        return sel ? rdy_b : rdy_a;
    endfunction

    function automatic logic sel_we();
        return sel ? we_b : we_a;
    endfunction

    // Every strobe on either instance must match the head of the scoreboard.
    task automatic chk_strobe(input logic [5:0] addr, input logic [31:0] data);
        wr_t e;
        if (sb_q.size() == 0) begin
            chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("strobe_addr", 32'(addr), 32'(e.addr));
            chk("strobe_data", data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (we_a) chk_strobe(addr_a, wdata_a);
        if (we_b) chk_strobe({4'b0, addr_b}, wdata_b);
    end

    // Called just after a negedge; returns just after the negedge that
    // follows the handshake (WRITE cycle, or ERROR state on rejection).
    task automatic send(input int kind, input int rd, input int rs1, input int rs2,
                        input int f3, input int f7b5, input int imm, input bit last,
                        input bit wr, input logic [31:0] word);
        int n;
        wr_t e;
        in_kind     = kind[2:0];
        in_rd       = rd[4:0];
        in_rs1      = rs1[4:0];
        in_rs2      = rs2[4:0];
        in_funct3   = f3[2:0];
        in_funct7b5 = f7b5[0];
        in_imm      = imm[20:0];
        in_last     = last;
        in_valid    = 1'b1;
        n = 0;
        while (!sel_rdy() && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!sel_rdy()) begin
            chk("ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (wr) begin
            e.addr = 6'(exp_addr);
            e.data = word;
            sb_q.push_back(e);
            exp_addr++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("we_after_handshake", 32'(sel_we()), 32'(wr));
        chk("ready_low_after_hs", 32'(sel_rdy()), 32'd0);
    endtask

    task automatic do_start(input bit b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        exp_addr = 0;
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_rdy"},   32'(rdy_a), 32'd0);
        chk({tag, "_we"},    32'(we_a), 32'd0);
        chk({tag, "_addr"},  32'(addr_a), 32'd0);
        chk({tag, "_wdata"}, wdata_a, 32'd0);
        chk({tag, "_count"}, 32'(count_a), 32'd0);
        chk({tag, "_busy"},  32'(busy_a), 32'd0);
        chk({tag, "_done"},  32'(done_a), 32'd0);
        chk({tag, "_err"},   32'(err_a), 32'd0);
        chk({tag, "_code"},  32'(code_a), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_a_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_ignores_valid", 32'(rdy_a), 32'd0);

        // Single addi x1,x0,5
        sel = 1'b0;
        do_start(1'b0);
        chk("accept_ready", 32'(rdy_a), 32'd1);
        chk("accept_busy", 32'(busy_a), 32'd1);
        send(4, 1, 0, 0, 0, 0, 5, 1'b1, 1'b1, 32'h00500093);
        @(negedge clk);
        chk("addi_done", 32'(done_a), 32'd1);
        chk("addi_count", 32'(count_a), 32'd1);
        chk("addi_busy", 32'(busy_a), 32'd0);

        // lw / sw / add / sub stream
        do_start(1'b0);
        chk("restart_count", 32'(count_a), 32'd0);
        chk("restart_done", 32'(done_a), 32'd0);
        send(0, 2, 1, 0, 0, 0, 8, 1'b0, 1'b1, 32'h0080A103);
        send(1, 0, 1, 2, 0, 0, 4, 1'b0, 1'b1, 32'h0020A223);
        send(2, 3, 1, 2, 0, 0, 0, 1'b0, 1'b1, 32'h002081B3);
        send(2, 3, 1, 2, 0, 1, 0, 1'b1, 1'b1, 32'h402081B3);
        @(negedge clk);
        chk("stream_done", 32'(done_a), 32'd1);
        chk("stream_count", 32'(count_a), 32'd4);

        // beq x1,x2,-4 ; jal x1,8
        do_start(1'b0);
        send(3, 0, 1, 2, 0, 0, -4, 1'b0, 1'b1, 32'hFE208EE3);
        send(5, 1, 0, 0, 0, 0, 8, 1'b1, 1'b1, 32'h008000EF);
        @(negedge clk);
        chk("branch_done", 32'(done_a), 32'd1);
        chk("branch_count", 32'(count_a), 32'd2);

        // Illegal kind
        do_start(1'b0);
        send(6, 1, 1, 1, 0, 0, 0, 1'b0, 1'b0, 32'h0);
        chk("kind6_err", 32'(err_a), 32'd1);
        chk("kind6_code", 32'(code_a), 32'd1);
        chk("kind6_count", 32'(count_a), 32'd0);

        // addi immediate out of range
        do_start(1'b0);
        chk("restart_err_clr", 32'(err_a), 32'd0);
        chk("restart_code_clr", 32'(code_a), 32'd0);
        send(4, 1, 0, 0, 0, 0, 2048, 1'b0, 1'b0, 32'h0);
        chk("imm2048_code", 32'(code_a), 32'd2);

        // beq even immediate accepted, odd rejected
        do_start(1'b0);
        send(3, 0, 1, 2, 0, 0, 6, 1'b0, 1'b1, 32'h00208363);
        send(3, 0, 1, 2, 0, 0, 5, 1'b0, 1'b0, 32'h0);
        chk("beq_odd_err", 32'(err_a), 32'd1);
        chk("beq_odd_code", 32'(code_a), 32'd2);
        chk("beq_odd_count", 32'(count_a), 32'd1);

        // Overflow on the ADDR_W=2 instance
        sel = 1'b1;
        do_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            send(4, i + 1, 0, 0, 0, 0, i, 1'b0, 1'b1,
                 {12'(i), 5'd0, 3'd0, 5'(i + 1), 7'b0010011});
        end
        @(negedge clk);
        chk("ovfl_err", 32'(err_b), 32'd1);
        chk("ovfl_code", 32'(code_b), 32'd3);
        chk("ovfl_count", 32'(count_b), 32'd4);
        in_kind  = 3'd4;
        in_imm   = 21'd9;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ovfl_fifth_ignored", 32'(rdy_b), 32'd0);
        end
        in_valid = 1'b0;
        chk("ovfl_sb_empty", 32'(sb_q.size()), 32'd0);
        do_start(1'b1);
        chk("ovfl_clr_count", 32'(count_b), 32'd0);
        chk("ovfl_clr_err", 32'(err_b), 32'd0);
        chk("ovfl_clr_code", 32'(code_b), 32'd0);
        chk("ovfl_clr_ready", 32'(rdy_b), 32'd1);

        // Reset both instances, then reset in the middle of a WRITE
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        sel = 1'b0;
        do_start(1'b0);
        send(4, 1, 0, 0, 0, 0, 5, 1'b0, 1'b1, 32'h00500093);
        send(4, 2, 0, 0, 0, 0, 7, 1'b0, 1'b1, 32'h00700113);
        reset_n = 1'b0;
        @(negedge clk);
        chk_a_zero("midwrite");
        reset_n = 1'b1;
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_reset_ready", 32'(rdy_a), 32'd0);
            chk("post_reset_busy", 32'(busy_a), 32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and program loader: the inverse of the main decoder. It accepts decoded instruction fields over a valid/ready handshake, packs them into 32-bit machine words for the six classes the core executes (lw, sw, R-type, beq, I-type ALU, jal), and writes them to consecutive instruction-memory words. It sits between a bench or debug host and the instruction-memory write port, and loads programs before the core is released from reset.

## Interface
- ADDR_W, 6, instruction-memory word-address width; capacity 2^ADDR_W words.
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  begins a load session and clears the address counter; honoured only in IDLE, DONE and ERROR.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept; high only in ACCEPT.
- in_kind  in  3  class: 0 lw, 1 sw, 2 R-type, 3 beq, 4 I-ALU, 5 jal; 6 and 7 are illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  used for R-type and I-ALU only.
- in_funct7b5  in  1  R-type only; sets bit 30 (sub).
- in_imm  in  21  signed byte immediate.
- in_last  in  1  marks the final instruction of the program.
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written this session.
- busy  out  1  high in ACCEPT and WRITE.
- done  out  1  program loaded.
- err  out  1  session aborted.
- err_code  out  2  01 illegal kind, 10 immediate out of range or odd, 11 memory overflow.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE: start moves to ACCEPT, count := 0.
- ACCEPT: in_ready = 1. On in_valid & in_ready, validate and encode into a register:
  - if the kind is illegal or the immediate fails its check, move to ERROR with the code; no write occurs.
  - otherwise move to WRITE.
- WRITE: mem_we = 1, mem_addr = count[ADDR_W-1:0], mem_wdata = encoded word; count increments at the end of the cycle. Next state:
  - in_last was set: DONE.
  - else count reaches 2^ADDR_W after this write: ERROR, code 11. The final write still completes.
  - else ACCEPT.
- DONE and ERROR: flag held high; start returns to ACCEPT with count := 0 and err_code := 00.
- Fixed fields: lw op 0000011 f3 010; sw op 0100011 f3 010; R op 0110011, funct7 = {0, in_funct7b5, 00000}; beq op 1100011 f3 000; I-ALU op 0010011; jal op 1101111. Fields a class does not use are zero.
- Immediate placement:
  - I: imm[11:0] to [31:20].
  - S: imm[11:5] to [31:25], imm[4:0] to [11:7].
  - B: imm[12] to 31, imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to 7.
  - J: imm[20] to 31, imm[10:1] to [30:21], imm[11] to 20, imm[19:12] to [19:12].
- Range checks:
  - I and S: in [-2048, 2047].
  - B: in [-4096, 4094] and even.
  - J: the full 21-bit range, and even.
  - R-type ignores in_imm.

## Timing
- Reset: state IDLE; all outputs 0 (in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err, err_code).
- Registered outputs. A handshake at edge N drives mem_we high for exactly the cycle after edge N.
- Throughput is one instruction per two cycles; in_ready is low during WRITE.
- in_valid while in_ready is low is ignored. The source holds its fields until the handshake.
- reset_n low in any state, including mid-WRITE, returns to reset values at the next edge. A strobe already on the port completes; no further write is issued.
- start during ACCEPT or WRITE has no effect.
- Address does not wrap. Overflow is reported, never overwritten.

## Test plan
- Reset, start, then addi x1,x0,5 (kind 4, f3 000, imm 5, last) -> one strobe at addr 0 with 0x00500093; done=1, count=1.
- Stream lw x2,8(x1); sw x2,4(x1); add x3,x1,x2; sub x3,x1,x2 (last) -> addr 0..3 receive 0x0080A103, 0x0020A223, 0x002081B3, 0x402081B3; each strobe one cycle after its handshake.
- beq x1,x2,-4 then jal x1,8 (last) -> 0xFE208EE3 and 0x008000EF.
- Illegal and out-of-range inputs:
  - kind 6 -> err=1, code 01, no strobe.
  - addi imm 2048 -> code 10.
  - beq imm 6 accepted; beq imm 5 -> code 10.
- ADDR_W=2, five instructions, none marked last -> four strobes at addr 0..3, then err code 11, count=4. A following start clears count, err and err_code.
- reset_n low during the WRITE cycle of the second instruction -> all outputs 0 and IDLE next cycle; in_valid ignored until start.
